// File: rtl/elastic_pipe_reg_pkg.sv
// Shared definitions for the elastic pipeline register: default word width,
// per-stage state encoding and the occupancy counter width helper.
package elastic_pipe_reg_pkg;

   localparam int unsigned WORD_SIZE = 32;

   typedef enum logic [1:0] {
      StEmpty,
      StFull,
      StSkid
   } stage_state_e;

   // Counter must represent 0..2*depth inclusive.
   function automatic int unsigned occ_width(input int unsigned depth);
      return $clog2(2 * depth + 1);
   endfunction

endpackage

// File: rtl/elastic_pipe_reg_skid_stage.sv
// One elastic stage: a main register plus a skid register, so the upstream
// ready is a pure register output and never depends on dn_ready.
module skid_stage
   import elastic_pipe_reg_pkg::*;
#(
   parameter int unsigned      WIDTH       = WORD_SIZE,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             up_valid,
   output logic             up_ready,
   input  logic [WIDTH-1:0] up_data,
   output logic             dn_valid,
   input  logic             dn_ready,
   output logic [WIDTH-1:0] dn_data
);

   stage_state_e     state_q;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic             acc;
   logic             take;

   assign up_ready = (state_q != StSkid);
   assign dn_valid = (state_q != StEmpty);
   assign dn_data  = main_q;

   assign acc  = up_valid & up_ready;
   assign take = dn_valid & dn_ready;

   // up_data is only captured on acc, so junk on an idle bus never lands in state.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         state_q <= StEmpty;
         main_q  <= RESET_VALUE;
         skid_q  <= RESET_VALUE;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (acc) begin
                  state_q <= StFull;
                  main_q  <= up_data;
               end
            end
            StFull: begin
               if (acc && take) begin
                  main_q <= up_data;
               end else if (acc) begin
                  state_q <= StSkid;
                  skid_q  <= up_data;
               end else if (take) begin
                  state_q <= StEmpty;
               end
            end
            StSkid: begin
               if (take) begin
                  state_q <= StFull;
                  main_q  <= skid_q;
               end
            end
            default: state_q <= StEmpty;
         endcase
      end
   end

endmodule

// File: rtl/elastic_pipe_reg.sv
// DEPTH-stage elastic pipeline register with valid/ready handshake, flush and
// an occupancy counter covering every main and skid slot.
module elastic_pipe_reg
   import elastic_pipe_reg_pkg::*;
#(
   parameter int unsigned      WIDTH       = WORD_SIZE,
   parameter int unsigned      DEPTH       = 2,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_data,
   output logic [occ_width(DEPTH)-1:0]  occupancy
);

   localparam int unsigned      OCC_W   = occ_width(DEPTH);
   localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(2 * DEPTH);

   logic [DEPTH:0]   chain_valid;
   logic [DEPTH:0]   chain_ready;
   logic [WIDTH-1:0] chain_data [DEPTH+1];
   logic [OCC_W-1:0] occ_q;
   logic             in_xfer;
   logic             out_xfer;

   assign chain_valid[0]     = in_valid;
   assign chain_data[0]      = in_data;
   assign in_ready           = chain_ready[0];
   assign out_valid          = chain_valid[DEPTH];
   assign out_data           = chain_data[DEPTH];
   assign chain_ready[DEPTH] = out_ready;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      skid_stage #(
         .WIDTH       (WIDTH),
         .RESET_VALUE (RESET_VALUE)
      ) u_stage (
         .clk      (clk),
         .reset    (reset),
         .flush    (flush),
         .up_valid (chain_valid[i]),
         .up_ready (chain_ready[i]),
         .up_data  (chain_data[i]),
         .dn_valid (chain_valid[i+1]),
         .dn_ready (chain_ready[i+1]),
         .dn_data  (chain_data[i+1])
      );
   end

   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid & out_ready;
   assign occupancy = occ_q;

   // A flushed input handshake is killed, so flush simply zeroes the count.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         occ_q <= '0;
      end else begin
         assert (!(in_xfer && !out_xfer && occ_q == OCC_MAX));
         assert (!(out_xfer && !in_xfer && occ_q == '0));
         unique case ({in_xfer, out_xfer})
            2'b10:   occ_q <= occ_q + OCC_W'(1);
            2'b01:   occ_q <= occ_q - OCC_W'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Bench for elastic_pipe_reg: directed vector table on a DEPTH=2 instance, plus
// randomized traffic on three configurations checked against a FIFO model.
module tb_elastic_pipe_reg;
   import elastic_pipe_reg_pkg::*;

   localparam int unsigned NDUT = 3;
   localparam int unsigned DEP [NDUT] = '{2, 1, 3};
   localparam int unsigned WID [NDUT] = '{32, 8, 32};

   typedef struct {
      logic        iv;
      logic [31:0] id;
      logic        ordy;
      logic        fl;
      logic        e_ov;
      logic [31:0] e_od;
      logic        e_ir;
      int unsigned e_occ;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush     [NDUT];
   logic        in_valid  [NDUT];
   logic        in_ready  [NDUT];
   logic [31:0] in_data   [NDUT];
   logic        out_valid [NDUT];
   logic        out_ready [NDUT];
   logic [31:0] out_data  [NDUT];
   logic [7:0]  occ       [NDUT];

   int          checks = 0;
   int          errors = 0;
   vec_t        vecs [$];

   // FIFO reference: circular buffer per instance, depth 8 covers 2*DEPTH <= 6.
   logic [31:0] mbuf  [NDUT][8];
   int unsigned mhead [NDUT];
   int unsigned mcnt  [NDUT];

   always #5 clk = ~clk;

   for (genvar k = 0; k < NDUT; k++) begin : g_dut
      localparam int unsigned W = WID[k];
      localparam int unsigned D = DEP[k];
      logic [W-1:0]              od;
      logic [occ_width(D)-1:0]   oc;
      elastic_pipe_reg #(
         .WIDTH       (W),
         .DEPTH       (D),
         .RESET_VALUE ('0)
      ) u_dut (
         .clk       (clk),
         .reset     (reset),
         .flush     (flush[k]),
         .in_valid  (in_valid[k]),
         .in_ready  (in_ready[k]),
         .in_data   (in_data[k][W-1:0]),
         .out_valid (out_valid[k]),
         .out_ready (out_ready[k]),
         .out_data  (od),
         .occupancy (oc)
      );
      assign out_data[k] = 32'(od);
      assign occ[k]      = 8'(oc);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      for (int k = 0; k < NDUT; k++) begin
         flush[k]     = 1'b0;
         in_valid[k]  = 1'b0;
         in_data[k]   = '0;
         out_ready[k] = 1'b0;
      end
   endtask

   function automatic void row(input logic iv, input logic [31:0] id, input logic ordy,
                               input logic fl, input logic eov, input logic [31:0] eod,
                               input logic eir, input int unsigned eocc);
      vec_t v;
      v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
      v.e_ov = eov; v.e_od = eod; v.e_ir = eir; v.e_occ = eocc;
      vecs.push_back(v);
   endfunction

   function automatic logic [31:0] mask_of(input int k);
      return (WID[k] == 32) ? 32'hFFFF_FFFF : ((32'h1 << WID[k]) - 32'h1);
   endfunction

   // Compare DUT k with the FIFO model, then apply this cycle's transfers.
   task automatic model_step(input int k, input bit do_check);
      if (do_check) begin
         check($sformatf("rnd_occ[%0d]", k), 32'(occ[k]), mcnt[k]);
         if (out_valid[k]) begin
            check($sformatf("rnd_valid_nonempty[%0d]", k), 32'(mcnt[k] != 0), 32'd1);
            if (mcnt[k] != 0)
               check($sformatf("rnd_order[%0d]", k), out_data[k], mbuf[k][mhead[k]]);
         end
         if (mcnt[k] >= 2 * DEP[k])
            check($sformatf("rnd_full_ready[%0d]", k), 32'(in_ready[k]), 32'd0);
      end
      if (out_valid[k] && out_ready[k] && mcnt[k] != 0) begin
         mhead[k] = (mhead[k] + 1) % 8;
         mcnt[k]--;
      end
      if (flush[k]) begin
         mcnt[k] = 0;
      end else if (in_valid[k] && in_ready[k] && mcnt[k] < 8) begin
         mbuf[k][(mhead[k] + mcnt[k]) % 8] = in_data[k] & mask_of(k);
         mcnt[k]++;
      end
   endtask

   initial begin
      reset = 1'b1;
      idle_all();

      // Streaming on DEPTH=2: entry accepted at cycle N shows at N+2.
      row(1, 32'h1, 1, 0, 0, 32'h0, 1, 0);
      row(1, 32'h2, 1, 0, 0, 32'h0, 1, 1);
      row(1, 32'h3, 1, 0, 1, 32'h1, 1, 2);
      row(1, 32'h4, 1, 0, 1, 32'h2, 1, 2);
      row(1, 32'h5, 1, 0, 1, 32'h3, 1, 2);
      row(1, 32'h6, 1, 0, 1, 32'h4, 1, 2);
      row(1, 32'h7, 1, 0, 1, 32'h5, 1, 2);
      row(1, 32'h8, 1, 0, 1, 32'h6, 1, 2);
      row(0, 32'h0, 1, 0, 1, 32'h7, 1, 2);
      row(0, 32'h0, 1, 0, 1, 32'h8, 1, 1);
      row(0, 32'h0, 1, 0, 0, 32'h0, 1, 0);
      // Backpressure: four accepts fill the pipe, then drain in order.
      row(1, 32'h10, 0, 0, 0, 32'h0, 1, 0);
      row(1, 32'h11, 0, 0, 0, 32'h0, 1, 1);
      row(1, 32'h12, 0, 0, 1, 32'h10, 1, 2);
      row(1, 32'h13, 0, 0, 1, 32'h10, 1, 3);
      row(0, 32'h0, 0, 0, 1, 32'h10, 0, 4);
      row(0, 32'h0, 1, 0, 1, 32'h10, 0, 4);
      row(0, 32'h0, 1, 0, 1, 32'h11, 0, 3);
      row(0, 32'h0, 1, 0, 1, 32'h12, 1, 2);
      row(0, 32'h0, 1, 0, 1, 32'h13, 1, 1);
      row(0, 32'h0, 1, 0, 0, 32'h0, 1, 0);
      // Flush mid-stall with a concurrent push of 0x55.
      row(1, 32'h21, 0, 0, 0, 32'h0, 1, 0);
      row(1, 32'h22, 0, 0, 0, 32'h0, 1, 1);
      row(1, 32'h23, 0, 0, 1, 32'h21, 1, 2);
      row(1, 32'h55, 0, 1, 1, 32'h21, 1, 3);
      row(0, 32'h0, 1, 0, 0, 32'h0, 1, 0);
      row(0, 32'h0, 1, 0, 0, 32'h0, 1, 0);
      row(0, 32'h0, 1, 0, 0, 32'h0, 1, 0);

      // Reset with live input on every instance.
      for (int k = 0; k < NDUT; k++) begin
         in_valid[k] = 1'b1;
         in_data[k]  = 32'hDEAD_BEEF;
      end
      tick();
      tick();
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
         check($sformatf("rst_ov[%0d]", k), 32'(out_valid[k]), 32'd0);
         check($sformatf("rst_od[%0d]", k), out_data[k], 32'd0);
         check($sformatf("rst_occ[%0d]", k), 32'(occ[k]), 32'd0);
         check($sformatf("rst_ir[%0d]", k), 32'(in_ready[k]), 32'd1);
      end
      tick();
      reset = 1'b0;
      idle_all();
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
         check($sformatf("post_rst_ov[%0d]", k), 32'(out_valid[k]), 32'd0);
         check($sformatf("post_rst_occ[%0d]", k), 32'(occ[k]), 32'd0);
         check($sformatf("post_rst_ir[%0d]", k), 32'(in_ready[k]), 32'd1);
      end
      tick();

      // Directed vector table on the DEPTH=2 instance.
      for (int i = 0; i < vecs.size(); i++) begin
         in_valid[0]  = vecs[i].iv;
         in_data[0]   = vecs[i].iv ? vecs[i].id : 'x;
         out_ready[0] = vecs[i].ordy;
         flush[0]     = vecs[i].fl;
         @(negedge clk);
         check($sformatf("tbl%0d_ov", i), 32'(out_valid[0]), 32'(vecs[i].e_ov));
         if (vecs[i].e_ov)
            check($sformatf("tbl%0d_od", i), out_data[0], vecs[i].e_od);
         check($sformatf("tbl%0d_ir", i), 32'(in_ready[0]), 32'(vecs[i].e_ir));
         check($sformatf("tbl%0d_occ", i), 32'(occ[0]), vecs[i].e_occ);
         tick();
      end
      idle_all();

      // Reset while the pipe is stalled full.
      for (int i = 0; i < 5; i++) begin
         in_valid[0] = 1'b1;
         in_data[0]  = 32'h30 + 32'(i);
         tick();
      end
      @(negedge clk);
      check("stall_full_ir", 32'(in_ready[0]), 32'd0);
      check("stall_full_occ", 32'(occ[0]), 32'd4);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      in_valid[0] = 1'b0;
      @(negedge clk);
      check("stall_rst_ov", 32'(out_valid[0]), 32'd0);
      check("stall_rst_od", out_data[0], 32'd0);
      check("stall_rst_occ", 32'(occ[0]), 32'd0);
      check("stall_rst_ir", 32'(in_ready[0]), 32'd1);
      tick();

      // Random traffic on all instances against the FIFO model.
      for (int k = 0; k < NDUT; k++) begin
         mhead[k] = 0;
         mcnt[k]  = 0;
      end
      for (int cyc = 0; cyc < 10000; cyc++) begin
         for (int k = 0; k < NDUT; k++) begin
            in_valid[k]  = ($urandom_range(0, 3) != 0);
            in_data[k]   = in_valid[k] ? $urandom() : 'x;
            out_ready[k] = ($urandom_range(0, 99) < (((cyc / 200) % 2 == 1) ? 85 : 25));
            flush[k]     = ($urandom_range(0, 99) == 0);
         end
         @(negedge clk);
         for (int k = 0; k < NDUT; k++) model_step(k, 1'b1);
         tick();
      end

      // Drain: every entry the model still holds must come out.
      for (int k = 0; k < NDUT; k++) begin
         in_valid[k]  = 1'b0;
         flush[k]     = 1'b0;
         out_ready[k] = 1'b1;
      end
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clk);
         for (int k = 0; k < NDUT; k++) model_step(k, 1'b1);
         tick();
      end
      @(negedge clk);
      for (int k = 0; k < NDUT; k++) begin
         check($sformatf("drain_model_empty[%0d]", k), mcnt[k], 32'd0);
         check($sformatf("drain_occ[%0d]", k), 32'(occ[k]), 32'd0);
         check($sformatf("drain_ov[%0d]", k), 32'(out_valid[k]), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
